// File: rtl/ibex_pkg.sv
// Shared types and constants for the IF-stage instruction aligner.
package ibex_pkg;

  localparam int HALFWORD_W = 16;

  // Where the next instruction starts relative to the fetch word stream.
  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HALF    = 2'd1,
    SKIP    = 2'd2
  } aligner_state_e;

  // One emitted instruction together with its side information.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic        err_plus2;
  } aligner_out_t;

  // RVC encodings never have both low opcode bits set.
  function automatic logic is_compressed(input logic [HALFWORD_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_instr_aligner_if.sv
// Fetch-word input and aligned-instruction output handshakes of the aligner.
// The slave modport is the aligner's view, the master modport the environment's.
interface ibex_instr_aligner_if;

  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic        out_err_plus2_o;

  modport slave (
    input  in_valid_i, in_rdata_i, in_err_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_err_o, out_err_plus2_o
  );

  modport master (
    output in_valid_i, in_rdata_i, in_err_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_err_o, out_err_plus2_o
  );

endinterface

// File: rtl/ibex_aligner_skid_buf.sv
// Generic 2-entry valid/ready register slice. Input ready depends only on the
// fill level, so no combinational path runs from out_ready_i to in_ready_o,
// and two entries keep full throughput while out_ready_i toggles.
// clr_i empties the slice and blocks any transfer in the same cycle.
module ibex_aligner_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign in_ready_o  = (r_count != 2'd2);
  assign out_valid_o = (r_count != 2'd0) && !clr_i;
  assign out_data_o  = r_mem[r_rd_ptr];
  assign w_push      = in_valid_i && in_ready_o && !clr_i;
  assign w_pop       = out_valid_o && out_ready_i;

  // Pointer and occupancy bookkeeping; clear and reset both empty the slice.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Payload storage needs no reset; occupancy guards it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (w_push && (r_wr_ptr == 1'(gi))) r_mem[gi] <= in_data_i;
    end
  end

endmodule

// File: rtl/ibex_instr_aligner.sv
// IF-stage instruction aligner: turns word-aligned fetch words into one
// instruction per handshake with its PC, handling RVC halfwords, 32-bit
// instructions straddling a word boundary and halfword-offset branch targets.
// Optional build macro IBEX_ALIGNER_OUT_REG_EN registers the outputs through a
// 2-entry skid buffer (1 cycle latency); without it the word-to-instruction
// path is purely combinational.
module ibex_instr_aligner
  import ibex_pkg::*;
#(
  parameter logic [31:0] ResetAddr = 32'h0000_0080
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [31:0]          flush_addr_i,
  ibex_instr_aligner_if.slave  bus
);

  aligner_state_e        r_state;
  aligner_state_e        w_state_next;
  logic [HALFWORD_W-1:0] r_stash;
  logic                  r_stash_err;
  logic [31:0]           r_addr;

  logic [31:0] w_word;
  logic        w_stash_is_c;
  logic        w_core_valid;
  logic        w_core_is_c;
  logic [31:0] w_core_instr;
  logic        w_core_err;
  logic        w_core_err_plus2;
  logic        w_in_ready;
  logic        w_down_ready;
  logic        w_out_fire;
  logic        w_in_fire;
  logic        w_stash_load;

  assign w_word       = bus.in_rdata_i;
  assign w_stash_is_c = is_compressed(r_stash);
  assign w_out_fire   = w_core_valid && w_down_ready;
  assign w_in_fire    = bus.in_valid_i && w_in_ready;
  // Every consumed word except a full 32-bit aligned instruction leaves its
  // upper halfword behind for the next instruction.
  assign w_stash_load = w_in_fire && ((r_state != ALIGNED) || w_core_is_c);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ALIGNED;
    else         r_state <= w_state_next;
  end

  // Next-state logic; a redirect overrides any handshake in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ALIGNED: if (w_out_fire && w_core_is_c)  w_state_next = HALF;
      HALF:    if (w_out_fire && w_stash_is_c) w_state_next = ALIGNED;
      SKIP:    if (w_in_fire)                  w_state_next = HALF;
      default: w_state_next = ALIGNED;
    endcase
    if (flush_i) w_state_next = flush_addr_i[1] ? SKIP : ALIGNED;
  end

  // Output logic: build the instruction from the stash and/or the input word.
  always_comb begin
    w_core_valid     = 1'b0;
    w_core_is_c      = 1'b0;
    w_core_instr     = 32'h0;
    w_core_err       = 1'b0;
    w_core_err_plus2 = 1'b0;
    w_in_ready       = 1'b0;
    case (r_state)
      ALIGNED: begin
        w_core_is_c  = is_compressed(w_word[HALFWORD_W-1:0]);
        w_core_instr = w_core_is_c ? {16'h0, w_word[HALFWORD_W-1:0]} : w_word;
        w_core_valid = bus.in_valid_i;
        w_core_err   = bus.in_err_i;
        w_in_ready   = w_down_ready;
      end
      HALF: begin
        if (w_stash_is_c) begin
          // Stash alone is a complete instruction; no word is needed.
          w_core_is_c  = 1'b1;
          w_core_instr = {16'h0, r_stash};
          w_core_valid = 1'b1;
          w_core_err   = r_stash_err;
        end else begin
          w_core_instr     = {w_word[HALFWORD_W-1:0], r_stash};
          w_core_valid     = bus.in_valid_i;
          w_core_err       = r_stash_err || bus.in_err_i;
          w_core_err_plus2 = !r_stash_err && bus.in_err_i;
          w_in_ready       = w_down_ready;
        end
      end
      SKIP: begin
        // Discard the low halfword below a halfword-offset branch target.
        w_in_ready = 1'b1;
      end
      default: ;
    endcase
    if (flush_i || !rst_ni) begin
      w_core_valid = 1'b0;
      w_in_ready   = 1'b0;
    end
  end

  // Stash and PC registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stash     <= '0;
      r_stash_err <= 1'b0;
      r_addr      <= ResetAddr;
    end else if (flush_i) begin
      r_stash     <= '0;
      r_stash_err <= 1'b0;
      r_addr      <= flush_addr_i & 32'hFFFF_FFFE;
    end else begin
      if (w_stash_load) begin
        r_stash     <= w_word[31:HALFWORD_W];
        r_stash_err <= bus.in_err_i;
      end
      if (w_out_fire) r_addr <= r_addr + (w_core_is_c ? 32'd2 : 32'd4);
    end
  end

  assign bus.in_ready_o = w_in_ready;

`ifdef IBEX_ALIGNER_OUT_REG_EN
  aligner_out_t w_skid_in;
  aligner_out_t w_skid_out;
  logic         w_skid_valid;

  assign w_skid_in = '{instr: w_core_instr, addr: r_addr,
                       err: w_core_err, err_plus2: w_core_err_plus2};

  ibex_aligner_skid_buf #(
    .W($bits(aligner_out_t))
  ) u_skid_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (flush_i),
    .in_valid_i (w_core_valid),
    .in_ready_o (w_down_ready),
    .in_data_i  (w_skid_in),
    .out_valid_o(w_skid_valid),
    .out_ready_i(bus.out_ready_i),
    .out_data_o (w_skid_out)
  );

  assign bus.out_valid_o     = w_skid_valid && rst_ni;
  assign bus.out_instr_o     = w_skid_out.instr;
  assign bus.out_addr_o      = w_skid_out.addr;
  assign bus.out_err_o       = w_skid_out.err && rst_ni;
  assign bus.out_err_plus2_o = w_skid_out.err_plus2 && rst_ni;
`else
  assign w_down_ready        = bus.out_ready_i;
  assign bus.out_valid_o     = w_core_valid;
  assign bus.out_instr_o     = w_core_instr;
  assign bus.out_addr_o      = r_addr;
  assign bus.out_err_o       = w_core_err && rst_ni;
  assign bus.out_err_plus2_o = w_core_err_plus2 && rst_ni;
`endif

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// Self-checking bench for ibex_instr_aligner (combinational build): directed
// scenarios plus randomized streams checked against a halfword-walk model.
module tb_ibex_instr_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;

  ibex_instr_aligner_if bus();

  ibex_instr_aligner #(.ResetAddr(32'h0000_0080)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .flush_addr_i(flush_addr),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Apply inputs at the falling edge, settle, then the caller samples.
  task automatic drive(input logic v, input logic [31:0] d, input logic e,
                       input logic rdy, input logic fl, input logic [31:0] fa);
    @(negedge clk);
    bus.in_valid_i  = v;
    bus.in_rdata_i  = d;
    bus.in_err_i    = e;
    bus.out_ready_i = rdy;
    flush           = fl;
    flush_addr      = fa;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] st;
    rst_n = 1'b0;
    drive(1'b1, 32'h00A0_0093, 1'b1, 1'b1, 1'b0, 32'h0);
    st = {bus.out_valid_o, bus.in_ready_o, bus.out_err_o, bus.out_err_plus2_o};
    n_tests++;
    if (st !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got %b want 0000", st); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_addr_o !== 32'h80) begin n_fail++; $display("FAIL reset_addr: got %h want 00000080", bus.out_addr_o); end
    n_tests++;
    if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", bus.out_valid_o); end
  endtask

  task automatic test_aligned();
    logic [31:0] w [2];
    w[0] = 32'h00A0_0093;
    w[1] = 32'h0041_0113;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, w[i], 1'b0, 1'b1, 1'b0, 32'h0);
      n_tests++;
      if ({bus.out_valid_o, bus.in_ready_o, bus.out_err_o} !== 3'b110) begin
        n_fail++; $display("FAIL aligned_hs%0d: got %b want 110", i, {bus.out_valid_o, bus.in_ready_o, bus.out_err_o});
      end
      n_tests++;
      if (bus.out_instr_o !== w[i]) begin n_fail++; $display("FAIL aligned_instr%0d: got %h want %h", i, bus.out_instr_o, w[i]); end
      n_tests++;
      if (bus.out_addr_o !== 32'h80 + 32'(4 * i)) begin
        n_fail++; $display("FAIL aligned_addr%0d: got %h want %h", i, bus.out_addr_o, 32'h80 + 32'(4 * i));
      end
    end
    $display("[TB] aligned: two 32-bit words emitted");
  endtask

  task automatic test_compressed_split();
    do_reset();
    drive(1'b1, 32'h0513_4501, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b11) begin n_fail++; $display("FAIL split_hs0: got %b want 11", {bus.out_valid_o, bus.in_ready_o}); end
    n_tests++;
    if (bus.out_instr_o !== 32'h0000_4501) begin n_fail++; $display("FAIL split_instr0: got %h want 00004501", bus.out_instr_o); end
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_instr_o !== 32'h0000_0513) begin n_fail++; $display("FAIL split_instr1: got %h want 00000513", bus.out_instr_o); end
    n_tests++;
    if (bus.out_addr_o !== 32'h82) begin n_fail++; $display("FAIL split_addr1: got %h want 00000082", bus.out_addr_o); end
    $display("[TB] split: c.li then straddling 32-bit instruction");
  endtask

  task automatic test_two_compressed();
    do_reset();
    drive(1'b1, 32'h4585_4501, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_instr_o !== 32'h0000_4501 || bus.out_addr_o !== 32'h80) begin
      n_fail++; $display("FAIL twoc_first: got %h@%h want 00004501@00000080", bus.out_instr_o, bus.out_addr_o);
    end
    drive(1'b1, 32'h00A0_0093, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b10) begin n_fail++; $display("FAIL twoc_hs1: got %b want 10", {bus.out_valid_o, bus.in_ready_o}); end
    n_tests++;
    if (bus.out_instr_o !== 32'h0000_4585 || bus.out_addr_o !== 32'h82) begin
      n_fail++; $display("FAIL twoc_second: got %h@%h want 00004585@00000082", bus.out_instr_o, bus.out_addr_o);
    end
    drive(1'b1, 32'h00A0_0093, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_instr_o !== 32'h00A0_0093 || bus.out_addr_o !== 32'h84 || bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL twoc_third: got %h@%h rdy %b want 00a00093@00000084 rdy 1", bus.out_instr_o, bus.out_addr_o, bus.in_ready_o);
    end
    // Reset while a compressed halfword is stashed: it must be dropped.
    do_reset();
    drive(1'b1, 32'h4585_4501, 1'b0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_during: got %b want 0", bus.out_valid_o); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_valid_o !== 1'b0 || bus.out_addr_o !== 32'h80) begin
      n_fail++; $display("FAIL midreset_after: got v%b@%h want v0@00000080", bus.out_valid_o, bus.out_addr_o);
    end
    $display("[TB] two compressed in one word, mid-instruction reset");
  endtask

  task automatic test_flush_halfword();
    do_reset();
    drive(1'b1, 32'h4501_FFFF, 1'b0, 1'b1, 1'b1, 32'h0000_1002);
    n_tests++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b00) begin n_fail++; $display("FAIL flush_cycle: got %b want 00", {bus.out_valid_o, bus.in_ready_o}); end
    drive(1'b1, 32'h4501_FFFF, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin n_fail++; $display("FAIL flush_bubble: got %b want 01", {bus.out_valid_o, bus.in_ready_o}); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_valid_o !== 1'b1 || bus.out_instr_o !== 32'h0000_4501 || bus.out_addr_o !== 32'h1002) begin
      n_fail++; $display("FAIL flush_target: got v%b %h@%h want v1 00004501@00001002", bus.out_valid_o, bus.out_instr_o, bus.out_addr_o);
    end
    $display("[TB] flush to halfword target 0x1002");
  endtask

  task automatic test_err_plus2();
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0082);
    drive(1'b1, 32'h0093_1234, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'h5678_00A0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if ({bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o} !== 3'b111 || bus.out_addr_o !== 32'h82) begin
      n_fail++; $display("FAIL errp2_straddle: got v/e/p2 %b@%h want 111@00000082",
                         {bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o}, bus.out_addr_o);
    end
    // Upper half of the faulting word is stashed with its error.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if ({bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o} !== 3'b110 || bus.out_addr_o !== 32'h86) begin
      n_fail++; $display("FAIL errp2_stash: got v/e/p2 %b@%h want 110@00000086",
                         {bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o}, bus.out_addr_o);
    end
    $display("[TB] error on second halfword of straddling instruction");
  endtask

  task automatic test_backpressure_flush();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      if (c < 3) begin
        drive(1'b1, 32'h00A0_0093, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus.out_valid_o, bus.in_ready_o} !== 2'b10 || bus.out_instr_o !== 32'h00A0_0093 || bus.out_addr_o !== 32'h80) begin
          n_fail++; $display("FAIL bp_hold%0d: got %b %h@%h want 10 00a00093@00000080", c,
                             {bus.out_valid_o, bus.in_ready_o}, bus.out_instr_o, bus.out_addr_o);
        end
      end else if (c == 3) begin
        drive(1'b1, 32'h00A0_0093, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        n_tests++;
        if ({bus.out_valid_o, bus.in_ready_o} !== 2'b00) begin n_fail++; $display("FAIL bp_flush: got %b want 00", {bus.out_valid_o, bus.in_ready_o}); end
      end else begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if (bus.out_valid_o !== 1'b0 || bus.out_addr_o !== 32'h200) begin
          n_fail++; $display("FAIL bp_after%0d: got v%b@%h want v0@00000200", c, bus.out_valid_o, bus.out_addr_o);
        end
      end
    end
    $display("[TB] backpressure for 5 cycles with flush in cycle 3");
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    drive(1'b1, 32'h4589_FFFF, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'h00A0_0093, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_instr_o !== 32'h0000_4589 || bus.out_addr_o !== 32'hFFFF_FFFE || bus.in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap_last: got %h@%h rdy %b want 00004589@fffffffe rdy 0", bus.out_instr_o, bus.out_addr_o, bus.in_ready_o);
    end
    drive(1'b1, 32'h00A0_0093, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_instr_o !== 32'h00A0_0093 || bus.out_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL wrap_zero: got %h@%h want 00a00093@00000000", bus.out_instr_o, bus.out_addr_o);
    end
    $display("[TB] PC wraps from 0xfffffffe to 0");
  endtask

  // Model: walk the halfword image from the target PC; a halfword with low
  // bits != 11 is a 2-byte instruction, otherwise it pairs with the next one.
  task automatic test_random(input int run);
    logic [15:0] hw [64];
    logic [31:0] words [32];
    logic        werr [32];
    logic [31:0] e_instr [$];
    logic [31:0] e_addr [$];
    logic        e_err [$];
    logic        e_p2 [$];
    logic [31:0] base;
    int          nw, hi, k, idx, cyc;
    logic        v, rdy, pending;

    nw   = $urandom_range(8, 30);
    base = 32'h0000_4000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    for (int j = 0; j < 2 * nw; j++) begin
      hw[j] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) hw[j][1:0] = 2'b11;
    end
    for (int j = 0; j < nw; j++) begin
      words[j] = {hw[2 * j + 1], hw[2 * j]};
      werr[j]  = ($urandom_range(0, 9) == 0);
    end
    hi = $urandom_range(0, 1);
    while (hi < 2 * nw) begin
      if (hw[hi][1:0] != 2'b11) begin
        e_instr.push_back({16'h0, hw[hi]});
        e_err.push_back(werr[hi / 2]);
        e_p2.push_back(1'b0);
        e_addr.push_back(base + 32'(2 * hi));
        hi += 1;
      end else begin
        if (hi + 1 >= 2 * nw) break;
        e_instr.push_back({hw[hi + 1], hw[hi]});
        e_err.push_back(werr[hi / 2] | werr[(hi + 1) / 2]);
        e_p2.push_back((hi % 2 == 1) && !werr[hi / 2] && werr[(hi + 1) / 2]);
        e_addr.push_back(base + 32'(2 * hi));
        hi += 2;
      end
    end

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, base + ((e_addr.size() > 0) ? (e_addr[0] - base) : 32'h0));
    k = 0; idx = 0; cyc = 0; pending = 1'b0;
    while (k < e_instr.size() && cyc < 2000) begin
      v   = (idx < nw) && (pending || $urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      pending = v;
      drive(v, (idx < nw) ? words[idx] : 32'h0, (idx < nw) ? werr[idx] : 1'b0, rdy, 1'b0, 32'h0);
      if (bus.out_valid_o && rdy) begin
        $display("[TB] run %0d txn %0d addr=%h instr=%h err=%b p2=%b", run, k,
                 bus.out_addr_o, bus.out_instr_o, bus.out_err_o, bus.out_err_plus2_o);
        n_tests++;
        if (bus.out_addr_o !== e_addr[k]) begin n_fail++; $display("FAIL rnd_addr: got %h want %h", bus.out_addr_o, e_addr[k]); end
        n_tests++;
        if ({bus.out_err_o, bus.out_err_plus2_o} !== {e_err[k], e_p2[k]}) begin
          n_fail++; $display("FAIL rnd_err: got %b want %b at %h", {bus.out_err_o, bus.out_err_plus2_o}, {e_err[k], e_p2[k]}, e_addr[k]);
        end
        if (!e_err[k]) begin
          n_tests++;
          if (bus.out_instr_o !== e_instr[k]) begin n_fail++; $display("FAIL rnd_instr: got %h want %h at %h", bus.out_instr_o, e_instr[k], e_addr[k]); end
        end
        k++;
      end
      if (v && bus.in_ready_o) begin
        idx++;
        pending = 1'b0;
      end
      cyc++;
    end
    n_tests++;
    if (k != e_instr.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d (cycle budget)", k, e_instr.size()); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_extra: got valid %b want 0", bus.out_valid_o); end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_rdata_i  = 32'h0;
    bus.in_err_i    = 1'b0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_aligned();
    test_compressed_split();
    test_two_compressed();
    test_flush_halfword();
    test_err_plus2();
    test_backpressure_flush();
    test_wrap();
    for (int r = 0; r < 8; r++) test_random(r);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_instr_aligner.md
Name: ibex_instr_aligner

Overview:
- Sits between the prefetch FIFO and the compressed decoder in the IF stage.
- Takes a stream of 32-bit word-aligned fetch words and emits one instruction per handshake, with its PC.
- Handles 16-bit instructions, 32-bit instructions that straddle a word boundary, and branch targets at halfword offsets.
- A compressed instruction is emitted in bits [15:0] with bits [31:16] zero. The downstream decoder expands it.

Parameters:
- ResetAddr, 32'h0000_0080, PC loaded into the address register on reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- flush_i  in  1  redirect; discards all buffered state
- flush_addr_i  in  32  new PC on flush; bit 0 is ignored
- in_valid_i  in  1  fetch word valid
- in_ready_o  out  1  word consumed this cycle
- in_rdata_i  in  32  fetch word, word-aligned
- in_err_i  in  1  bus error on this word
- out_valid_o  out  1  instruction valid
- out_ready_i  in  1  consumer accepts
- out_instr_o  out  32  aligned instruction
- out_addr_o  out  32  PC of out_instr_o
- out_err_o  out  1  instruction touched a faulting word
- out_err_plus2_o  out  1  fault lies only in the second halfword

Behaviour:
- Reset (synchronous, rst_ni low at a clock edge):
  - state=ALIGNED, stash_q=0, stash_err_q=0, addr_q=ResetAddr.
  - Outputs during reset: out_valid_o=0, in_ready_o=0, out_err_o=0, out_err_plus2_o=0.
- State machine, enum aligner_state_e:
  - ALIGNED: the next instruction starts at bit 0 of the next input word.
    - w[1:0]!=2'b11: emit {16'h0,w[15:0]}. On handshake, consume w, stash w[31:16] and its err, go to HALF.
    - Otherwise: emit w. On handshake, consume w, stay in ALIGNED.
    - out_valid_o=in_valid_i; in_ready_o=out_ready_i.
  - HALF: stash_q holds the halfword at addr_q.
    - stash_q[1:0]!=2'b11: emit {16'h0,stash_q} without an input word. out_valid_o=1, in_ready_o=0. Go to ALIGNED on handshake.
    - Otherwise: emit {w[15:0],stash_q} with out_valid_o=in_valid_i and in_ready_o=out_ready_i. On handshake, stash w[31:16] and stay in HALF.
  - SKIP: entered on flush when flush_addr_i[1]=1.
    - in_ready_o=1, out_valid_o=0.
    - On an input word, stash w[31:16] and go to HALF. This costs a 1-cycle bubble.
- addr_q: out_addr_o=addr_q. On each output handshake, add 2 for a compressed instruction and 4 otherwise, with 32-bit wrap-around (no saturation).
- Errors:
  - out_err_o = error on any word contributing to the instruction.
  - out_err_plus2_o=1 only when in HALF, the stash is clean and the new word faulted.
  - An errored instruction is still emitted once. Its payload is don't-care.
- Flush:
  - Highest priority. Any same-cycle handshake is ignored; the word is not consumed, so in_ready_o is forced to 0 that cycle.
  - Next cycle: state=SKIP if flush_addr_i[1] else ALIGNED; addr_q={flush_addr_i[31:1],1'b0}; stash cleared.
  - out_valid_o=0 in the flush cycle.
- Reset asserted mid-instruction drops any stash; no partial instruction is emitted.
- Base latency: combinational word-to-instruction path, 0 cycles. Backpressure holds all state.

Optional Feature:
- Macro: IBEX_ALIGNER_OUT_REG_EN.
- When defined:
  - A 2-entry skid buffer registers out_instr_o, out_addr_o, out_err_o and out_err_plus2_o.
  - Latency becomes 1 cycle.
  - Full throughput is kept under out_ready_i toggling.
  - flush_i empties the skid buffer in the same cycle.
  - in_ready_o no longer depends combinationally on out_ready_i.
- When undefined: the combinational behaviour above.

Decomposition:
- ibex_pkg holds aligner_state_e {ALIGNED, HALF, SKIP} and the localparam HALFWORD_W=16.
- One sub-module, ibex_aligner_skid_buf: a generic 2-entry valid/ready register slice, instantiated only under the macro.

Test Plan:
- Reset, then words 32'h00A0_0093, 32'h0041_0113 with out_ready_i=1:
  - Two outputs, addr 0x80 then 0x84.
  - Instructions equal the words; out_err_o=0.
- Word 32'h0513_4501 (c.li followed by the low half of a 32-bit instruction), then 32'h0000_0000:
  - Output {16'h0,16'h4501} at 0x80.
  - Then {16'h0000,16'h0513} at 0x82.
  - in_ready_o=0 never stalls the first word.
- Word 32'h4585_4501:
  - Two compressed outputs at 0x80 and 0x82.
  - in_ready_o=0 during the second output; the next word is consumed afterwards.
- Flush to 0x0000_1002, then word 32'h4501_FFFF:
  - One bubble, then {16'h0,16'h4501} at 0x1002.
  - The low half 0xFFFF is never emitted.
- HALF with stash 0x0093 (32-bit low half), then next word 32'hxxxx_00A0 with in_err_i=1:
  - out_err_o=1 and out_err_plus2_o=1 at the stash address.
- out_ready_i held low for 5 cycles with a valid word present:
  - Outputs stable; in_ready_o=0.
  - flush_i in cycle 3 drops the word; out_valid_o=0 in the cycle after.
